// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: same-cycle stall/flush decisions for the 5-stage core,
// plus a small FSM covering memory wait, halt drain and the halted state.
module pipe_hazard_ctrl #(
   parameter int BITS        = 32,
   parameter int REG_WORDS   = 32,
   parameter int ADDR_LEFT   = $clog2(REG_WORDS)-1,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic [ADDR_LEFT:0] raddr1_s2,
   input  logic [ADDR_LEFT:0] raddr2_s2,
   input  logic             use_r1_s2,
   input  logic             use_r2_s2,
   input  logic             branch_taken_s2,
   input  logic             halt_s2,
   input  logic             sel_mem_s3,
   input  logic             rw_s3,
   input  logic [ADDR_LEFT:0] waddr_s3,
   input  logic             mem_req_s4,
   input  logic             mem_ready,
   input  logic             halt_s5,
   output logic             en_pc,
   output logic             en_s2,
   output logic             en_s3,
   output logic             en_s4,
   output logic             en_s5,
   output logic             flush_s2,
   output logic             flush_s3,
   output logic             flush_s5,
   output logic             halted,
   output logic             mem_err,
   output logic [BITS-1:0]  stall_cycles
);

   localparam int CW = $clog2(MEM_TIMEOUT+1);

   typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

   state_t          state, state_nxt;
   logic            ret_drain;
   logic [CW-1:0]   wait_cnt;
   logic            lu, ms, timeout, drain_mode;

   assign ms = mem_req_s4 & ~mem_ready;
   assign lu = sel_mem_s3 & rw_s3 & (waddr_s3 != '0) &
               ((use_r1_s2 & (raddr1_s2 == waddr_s3)) | (use_r2_s2 & (raddr2_s2 == waddr_s3)));
   assign timeout = (state == MEM_WAIT) & ms & (wait_cnt == CW'(MEM_TIMEOUT-1));
   // The release cycle of a wait that interrupted a drain must keep inserting bubbles.
   assign drain_mode = (state == DRAIN) | ((state == MEM_WAIT) & ret_drain);
   assign halted = (state == HALTED);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) state <= RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (ms)                  state_nxt = MEM_WAIT;
            else if (halt_s5)        state_nxt = HALTED;
            else if (halt_s2 & ~lu)  state_nxt = DRAIN;
         end
         MEM_WAIT: begin
            if (timeout)             state_nxt = HALTED;
            else if (!ms) begin
               if (halt_s5)                            state_nxt = HALTED;
               else if (ret_drain | (halt_s2 & ~lu))   state_nxt = DRAIN;
               else                                    state_nxt = RUN;
            end
         end
         DRAIN: begin
            if (ms)                  state_nxt = MEM_WAIT;
            else if (halt_s5)        state_nxt = HALTED;
         end
         default:                    state_nxt = HALTED;
      endcase
   end

   always_comb begin
      en_pc    = 1'b1;
      en_s2    = 1'b1;
      en_s3    = 1'b1;
      en_s4    = 1'b1;
      en_s5    = 1'b1;
      flush_s2 = 1'b0;
      flush_s3 = 1'b0;
      flush_s5 = 1'b0;
      if (!rst_ || state == HALTED) begin
         {en_pc, en_s2, en_s3, en_s4, en_s5} = '0;
      end else if (ms) begin
         {en_pc, en_s2, en_s3, en_s4} = '0;
         flush_s5 = 1'b1;
      end else begin
         if (drain_mode) begin
            en_pc    = 1'b0;
            flush_s2 = 1'b1;
         end
         // A load-use stall holds IF/ID, so any branch squash waits for the re-evaluation.
         if (lu) begin
            en_pc    = 1'b0;
            en_s2    = 1'b0;
            flush_s2 = 1'b0;
            flush_s3 = 1'b1;
         end else if (branch_taken_s2) begin
            flush_s2 = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         ret_drain    <= 1'b0;
         wait_cnt     <= '0;
         mem_err      <= 1'b0;
         stall_cycles <= '0;
      end else begin
         if (state != MEM_WAIT) ret_drain <= (state == DRAIN);
         wait_cnt <= (state == MEM_WAIT) ? wait_cnt + CW'(1) : '0;
         if (timeout) mem_err <= 1'b1;
         if ((ms | lu) && state != HALTED && stall_cycles != '1)
            stall_cycles <= stall_cycles + BITS'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, memory stalls, halt drain, timeout and saturation.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_;
   logic [4:0] raddr1_s2, raddr2_s2, waddr_s3;
   logic       use_r1_s2, use_r2_s2, branch_taken_s2, halt_s2;
   logic       sel_mem_s3, rw_s3, mem_req_s4, mem_ready, halt_s5;
   logic       en_pc, en_s2, en_s3, en_s4, en_s5;
   logic       flush_s2, flush_s3, flush_s5, halted, mem_err;
   logic [7:0] stall_cycles;
   logic [4:0] en;
   logic [2:0] fl;
   int         pass_cnt = 0;
   int         tot_cnt  = 0;

   assign en = {en_pc, en_s2, en_s3, en_s4, en_s5};
   assign fl = {flush_s2, flush_s3, flush_s5};

   pipe_hazard_ctrl #(.BITS(8), .REG_WORDS(32), .MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst_(rst_),
      .raddr1_s2(raddr1_s2), .raddr2_s2(raddr2_s2), .use_r1_s2(use_r1_s2), .use_r2_s2(use_r2_s2),
      .branch_taken_s2(branch_taken_s2), .halt_s2(halt_s2),
      .sel_mem_s3(sel_mem_s3), .rw_s3(rw_s3), .waddr_s3(waddr_s3),
      .mem_req_s4(mem_req_s4), .mem_ready(mem_ready), .halt_s5(halt_s5),
      .en_pc(en_pc), .en_s2(en_s2), .en_s3(en_s3), .en_s4(en_s4), .en_s5(en_s5),
      .flush_s2(flush_s2), .flush_s3(flush_s3), .flush_s5(flush_s5),
      .halted(halted), .mem_err(mem_err), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic idle();
      raddr1_s2 = '0; raddr2_s2 = '0; waddr_s3 = '0;
      use_r1_s2 = 0; use_r2_s2 = 0; branch_taken_s2 = 0; halt_s2 = 0;
      sel_mem_s3 = 0; rw_s3 = 0; mem_req_s4 = 0; mem_ready = 0; halt_s5 = 0;
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      idle();
      rst_ = 1'b0;
      #4;
      rst_ = 1'b1;
      tick();
   endtask

   task automatic set_load_r5();
      sel_mem_s3 = 1; rw_s3 = 1; waddr_s3 = 5'd5;
   endtask

   task automatic test_reset();
      idle();
      rst_ = 1'b0;
      #3;
      tot_cnt++; if ({en, fl} !== 8'b0) $display("FAIL reset_ctrl en/fl=%b exp 00000000", {en, fl}); else pass_cnt++;
      tot_cnt++; if ({halted, mem_err} !== 2'b00) $display("FAIL reset_flags halted/err=%b exp 00", {halted, mem_err}); else pass_cnt++;
      tot_cnt++; if (stall_cycles !== 8'd0) $display("FAIL reset_stall got %0d exp 0", stall_cycles); else pass_cnt++;
      rst_ = 1'b1;
      tick(); #1;
      tot_cnt++; if ({en, fl} !== 8'b11111_000) $display("FAIL post_reset en/fl=%b exp 11111000", {en, fl}); else pass_cnt++;
   endtask

   task automatic test_load_use();
      do_reset();
      set_load_r5(); use_r2_s2 = 1; raddr2_s2 = 5'd5; #1;
      tot_cnt++; if ({en, fl} !== 8'b00111_010) $display("FAIL lu_r2 en/fl=%b exp 00111010", {en, fl}); else pass_cnt++;
      tick(); idle(); #1;
      tot_cnt++; if ({en, fl} !== 8'b11111_000) $display("FAIL lu_release en/fl=%b exp 11111000", {en, fl}); else pass_cnt++;
      tot_cnt++; if (stall_cycles !== 8'd1) $display("FAIL lu_count got %0d exp 1", stall_cycles); else pass_cnt++;
      sel_mem_s3 = 1; rw_s3 = 1; waddr_s3 = 5'd0; use_r2_s2 = 1; raddr2_s2 = 5'd0; #1;
      tot_cnt++; if ({en, fl} !== 8'b11111_000) $display("FAIL lu_r0 en/fl=%b exp 11111000", {en, fl}); else pass_cnt++;
      tick(); idle();
      set_load_r5(); raddr1_s2 = 5'd5; use_r1_s2 = 0; #1;
      tot_cnt++; if ({en, fl} !== 8'b11111_000) $display("FAIL lu_r1_unused en/fl=%b exp 11111000", {en, fl}); else pass_cnt++;
      use_r1_s2 = 1; rw_s3 = 0; #1;
      tot_cnt++; if ({en, fl} !== 8'b11111_000) $display("FAIL lu_no_write en/fl=%b exp 11111000", {en, fl}); else pass_cnt++;
      rw_s3 = 1; #1;
      tot_cnt++; if ({en, fl} !== 8'b00111_010) $display("FAIL lu_r1 en/fl=%b exp 00111010", {en, fl}); else pass_cnt++;
      tick(); idle(); #1;
      tot_cnt++; if (stall_cycles !== 8'd2) $display("FAIL lu_count2 got %0d exp 2", stall_cycles); else pass_cnt++;
   endtask

   task automatic test_mem_stall();
      do_reset();
      mem_req_s4 = 1; mem_ready = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         tot_cnt++; if ({en, fl} !== 8'b00001_001) $display("FAIL ms_cycle%0d en/fl=%b exp 00001001", c, {en, fl}); else pass_cnt++;
         tick();
      end
      mem_ready = 1; branch_taken_s2 = 0; #1;
      tot_cnt++; if ({en, fl} !== 8'b11111_000) $display("FAIL ms_release en/fl=%b exp 11111000", {en, fl}); else pass_cnt++;
      tick(); idle(); #1;
      tot_cnt++; if (stall_cycles !== 8'd3) $display("FAIL ms_count got %0d exp 3", stall_cycles); else pass_cnt++;
      tot_cnt++; if ({en, fl} !== 8'b11111_000) $display("FAIL ms_after en/fl=%b exp 11111000", {en, fl}); else pass_cnt++;
   endtask

   task automatic test_lu_branch();
      do_reset();
      set_load_r5(); use_r2_s2 = 1; raddr2_s2 = 5'd5; branch_taken_s2 = 1; #1;
      tot_cnt++; if ({en, fl} !== 8'b00111_010) $display("FAIL lu_br en/fl=%b exp 00111010", {en, fl}); else pass_cnt++;
      tick(); sel_mem_s3 = 0; #1;
      tot_cnt++; if ({en, fl} !== 8'b11111_100) $display("FAIL br_after en/fl=%b exp 11111100", {en, fl}); else pass_cnt++;
      tick(); idle();
   endtask

   task automatic test_halt();
      do_reset();
      halt_s2 = 1; #1;
      tot_cnt++; if ({en, fl} !== 8'b11111_000) $display("FAIL halt_n en/fl=%b exp 11111000", {en, fl}); else pass_cnt++;
      tick(); halt_s2 = 0; #1;
      tot_cnt++; if ({en, fl, halted} !== 9'b01111_100_0) $display("FAIL halt_n1 en/fl/h=%b exp 011111000", {en, fl, halted}); else pass_cnt++;
      tick(); #1;
      tot_cnt++; if ({en, fl} !== 8'b01111_100) $display("FAIL halt_n2 en/fl=%b exp 01111100", {en, fl}); else pass_cnt++;
      tick(); halt_s5 = 1; #1;
      tot_cnt++; if ({en, fl, halted} !== 9'b01111_100_0) $display("FAIL halt_n3 en/fl/h=%b exp 011111000", {en, fl, halted}); else pass_cnt++;
      tick(); halt_s5 = 0; #1;
      tot_cnt++; if ({en, fl, halted} !== 9'b00000_000_1) $display("FAIL halt_n4 en/fl/h=%b exp 000000001", {en, fl, halted}); else pass_cnt++;
      tick(); branch_taken_s2 = 1; mem_req_s4 = 1; set_load_r5(); #1;
      tot_cnt++; if ({en, fl, halted} !== 9'b00000_000_1) $display("FAIL halt_hold en/fl/h=%b exp 000000001", {en, fl, halted}); else pass_cnt++;
      idle();
   endtask

   task automatic test_halt_ms();
      do_reset();
      halt_s2 = 1;
      tick(); halt_s2 = 0;
      tick(); mem_req_s4 = 1; mem_ready = 0; #1;
      tot_cnt++; if ({en, fl} !== 8'b00001_001) $display("FAIL hms_n2 en/fl=%b exp 00001001", {en, fl}); else pass_cnt++;
      tick(); halt_s5 = 1; #1;
      tot_cnt++; if ({en, fl} !== 8'b00001_001) $display("FAIL hms_n3 en/fl=%b exp 00001001", {en, fl}); else pass_cnt++;
      tick(); halt_s5 = 0; mem_ready = 1; #1;
      tot_cnt++; if ({en, fl, halted} !== 9'b01111_100_0) $display("FAIL hms_n4 en/fl/h=%b exp 011111000", {en, fl, halted}); else pass_cnt++;
      tick(); mem_req_s4 = 0; mem_ready = 0; halt_s5 = 1; #1;
      tot_cnt++; if ({en, fl, halted} !== 9'b01111_100_0) $display("FAIL hms_n5 en/fl/h=%b exp 011111000", {en, fl, halted}); else pass_cnt++;
      tick(); halt_s5 = 0; #1;
      tot_cnt++; if ({en, halted} !== 6'b00000_1) $display("FAIL hms_n6 en/h=%b exp 000001", {en, halted}); else pass_cnt++;
      tot_cnt++; if (stall_cycles !== 8'd2) $display("FAIL hms_count got %0d exp 2", stall_cycles); else pass_cnt++;
   endtask

   task automatic test_timeout_reset();
      do_reset();
      mem_req_s4 = 1; mem_ready = 0;
      for (int c = 0; c < 5; c++) begin
         #1;
         tot_cnt++; if ({halted, mem_err} !== 2'b00) $display("FAIL to_wait%0d halted/err=%b exp 00", c, {halted, mem_err}); else pass_cnt++;
         tick();
      end
      #1;
      tot_cnt++; if ({halted, mem_err, en} !== 7'b11_00000) $display("FAIL to_fire h/err/en=%b exp 1100000", {halted, mem_err, en}); else pass_cnt++;
      tick();
      tot_cnt++; if (mem_err !== 1'b1) $display("FAIL to_sticky err=%b exp 1", mem_err); else pass_cnt++;
      rst_ = 1'b0; #1;
      tot_cnt++; if ({halted, mem_err, stall_cycles} !== 10'b0) $display("FAIL to_reset h/err/stall=%b exp 0", {halted, mem_err, stall_cycles}); else pass_cnt++;
      rst_ = 1'b1;
      tick(); tick(); tick(); #2;
      rst_ = 1'b0; #1;
      tot_cnt++; if ({en, fl, stall_cycles} !== 16'b0) $display("FAIL mid_wait_reset en/fl/stall=%b exp 0", {en, fl, stall_cycles}); else pass_cnt++;
      idle();
      #1 rst_ = 1'b1;
      tick(); #1;
      tot_cnt++; if ({en, fl} !== 8'b11111_000) $display("FAIL reset_release en/fl=%b exp 11111000", {en, fl}); else pass_cnt++;
      mem_req_s4 = 1; #1;
      tot_cnt++; if ({en, fl} !== 8'b00001_001) $display("FAIL rerun_ms en/fl=%b exp 00001001", {en, fl}); else pass_cnt++;
      idle();
   endtask

   task automatic test_saturation();
      do_reset();
      set_load_r5(); use_r1_s2 = 1; raddr1_s2 = 5'd5;
      repeat (254) tick();
      tot_cnt++; if (stall_cycles !== 8'd254) $display("FAIL sat_254 got %0d exp 254", stall_cycles); else pass_cnt++;
      repeat (10) tick();
      tot_cnt++; if (stall_cycles !== 8'd255) $display("FAIL sat_hold got %0d exp 255", stall_cycles); else pass_cnt++;
      idle();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_mem_stall();
      test_lu_branch();
      test_halt();
      test_halt_ms();
      test_timeout_reset();
      test_saturation();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It drives the load-enable and flush (bubble-insert) controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch squashes, multi-cycle data-memory stalls and halt draining. It sits beside the pipeline registers and produces same-cycle stall/flush decisions from stage-tagged control bits, with a small FSM for memory wait, drain and halt.

## Interface
- BITS, 32, datapath width (stall counter width)
- REG_WORDS, 32, register file entries
- ADDR_LEFT, $clog2(REG_WORDS)-1, MSB of register address
- MEM_TIMEOUT, 64, max consecutive memory-wait cycles before error
- clk  in  1  clock; all state updates on posedge
- rst_  in  1  asynchronous, active-low reset
- raddr1_s2, raddr2_s2  in  ADDR_LEFT+1  source registers of the instruction in ID
- use_r1_s2, use_r2_s2  in  1  instruction in ID reads raddr1/raddr2
- branch_taken_s2  in  1  branch/jump resolved taken in ID
- halt_s2  in  1  halt instruction in ID
- sel_mem_s3, rw_s3  in  1  instruction in EX is a load / writes the register file
- waddr_s3  in  ADDR_LEFT+1  destination of the instruction in EX
- mem_req_s4  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- halt_s5  in  1  halt reached WB
- en_pc, en_s2, en_s3, en_s4, en_s5  out  1  load enables: PC, IF/ID, ID/EX, EX/MEM, MEM/WB
- flush_s2, flush_s3, flush_s5  out  1  load a bubble (all-zero control) into IF/ID, ID/EX, MEM/WB
- halted  out  1  core stopped
- mem_err  out  1  sticky memory-timeout error
- stall_cycles  out  BITS  saturating count of stall cycles

## Operation
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED. Reset state is RUN.
- Load-use hazard (lu) is asserted when all of the following hold:
  - sel_mem_s3 & rw_s3 & waddr_s3!=0
  - and either (use_r1_s2 & raddr1_s2==waddr_s3) or (use_r2_s2 & raddr2_s2==waddr_s3)
- Memory stall (ms) is mem_req_s4 & !mem_ready.
- Priority, highest first: HALTED, ms, lu, branch_taken_s2. Defaults: all en_*=1, all flush_*=0.
  - HALTED: all en_*=0, all flush_*=0, halted=1.
  - ms (any non-HALTED state): en_pc=en_s2=en_s3=en_s4=0; en_s5=1, flush_s5=1. All other inputs are ignored that cycle.
  - lu: en_pc=en_s2=0, flush_s3=1. Any branch_taken_s2 that cycle is ignored; it is re-evaluated after the stall.
  - branch_taken_s2: flush_s2=1.
- In DRAIN, en_pc=0 and flush_s2=1 every non-ms cycle, so bubbles follow the halt down the pipe. lu is still honoured.
- Transitions:
  - RUN -> MEM_WAIT on ms.
  - RUN -> DRAIN on halt_s2 & !ms & !lu.
  - MEM_WAIT -> RUN or DRAIN on !ms, back to the state held before the wait.
  - Any state -> HALTED on halt_s5 & !ms.
  - MEM_WAIT -> HALTED with mem_err=1 when the wait counter reaches MEM_TIMEOUT.
- Wait counter: cleared on entry to MEM_WAIT, increments each MEM_WAIT cycle, width $clog2(MEM_TIMEOUT+1).
- HALTED exits only by reset.
- stall_cycles increments on any cycle with ms or lu asserted and saturates at 2^BITS-1.
- mem_err is sticky until reset.

## Timing
- en_*/flush_* are combinational from the current inputs and state: zero-latency, same-cycle decision. halted and mem_err are registered.
- A lu stall lasts exactly 1 cycle; the load then advances to MEM and lu deasserts.
- An ms stall lasts as long as mem_ready=0. Release happens in the cycle mem_ready=1, and full enables resume in that same cycle.
- Halt: halt_s2 at cycle N gives DRAIN from N+1 and halt_s5 at N+3 with no stalls. halted=1 from N+4.
- During rst_=0: all en_*=0 and flush_*=0. State RUN, halted=0, mem_err=0, stall_cycles=0, wait counter 0.
- Reset asserted mid-MEM_WAIT or mid-DRAIN returns to RUN immediately and asynchronously.
- Simultaneous halt_s5 and ms: ms wins and the HALTED transition waits until the memory completes.

## Test plan
- Load r5 in EX (sel_mem_s3=1, rw_s3=1, waddr_s3=5), ID uses r5 via raddr2 -> one cycle with en_pc=en_s2=0, flush_s3=1, stall_cycles=1. The same case with waddr_s3=0 produces no stall.
- mem_req_s4=1 with mem_ready low for 3 cycles -> en_pc..en_s4=0, flush_s5=1 for 3 cycles. Full enables resume on the mem_ready cycle, and stall_cycles=3.
- lu and branch_taken_s2 in the same cycle -> only flush_s3=1, flush_s2=0. The next cycle with branch still taken gives flush_s2=1.
- halt_s2 at cycle 10 with no stalls -> en_pc=0 and flush_s2=1 from cycle 11, halted=1 at cycle 14 with all en_*=0. Injecting a 2-cycle ms at cycle 12 delays halted to cycle 16.
- mem_ready held 0 with MEM_TIMEOUT=4 -> mem_err=1 and halted=1 after 4 wait cycles. Deasserting rst_ mid-wait clears everything, and en_* return to 1 after reset release.
- Force stall_cycles near saturation (lu every cycle with BITS=8) -> the counter holds at 255.
